hs_rx_sync_fifo: RTL
====================

Name: hs_rx_sync_fifo

Overview:
Parametrised receive-side endpoint for the 4-phase req/ack handshake between clock domains. It does the following:
- Synchronises the incoming asynchronous req into the clk1 domain through a configurable flop chain.
- Captures the held data word and returns ack.
- Buffers captured words in a small first-word-fall-through FIFO with valid/ready output.
It replaces the fixed 8-bit single-register receiver. Backpressure is applied by withholding ack while the FIFO is full.

Parameters:
DATA_W, 8, data word width (>=1)
SYNC_STAGES, 2, req synchroniser depth in flops (>=2)
FIFO_DEPTH, 4, output buffer entries (power of two, >=2)

Ports:
clk1  in  1  receive-domain clock
rst  in  1  reset, asynchronous, active-high
req  in  1  handshake request from sender domain (asynchronous)
data_in  in  DATA_W  sender data; held stable by the sender while req=1
ack  out  1  handshake acknowledge, registered in clk1
out_data  out  DATA_W  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accept; pop when out_valid&&out_ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
stall  out  1  req seen but FIFO full (state HOLD)

Behaviour:
- Reset (async assert, sync release):
  - outputs: ack=0, out_valid=0, out_data=0, fifo_level=0, stall=0
  - internal: synchroniser flops=0, FIFO pointers=0, state=IDLE.
- req_s is the last flop of the SYNC_STAGES chain. data_in is never synchronised; it is sampled only when req_s=1.
- FSM, evaluated at each clk1 rising edge:
  - IDLE (ack=0):
    - req_s=1 and level<FIFO_DEPTH: push data_in, ack<=1, go to ACK_HI.
    - req_s=1 and level==FIFO_DEPTH: go to HOLD.
    - otherwise stay in IDLE.
  - HOLD (ack=0, stall=1):
    - level<FIFO_DEPTH: push data_in, ack<=1, go to ACK_HI.
    - req_s=0 (sender aborted; protocol violation): return to IDLE, no push.
  - ACK_HI (ack=1): wait for req_s=0, then ack<=0 and go to IDLE. No new capture is possible until IDLE is re-entered.
- Latency:
  - req rise (setup-met) to ack rise: SYNC_STAGES+1 clk1 edges when FIFO not full.
  - req fall to ack fall: SYNC_STAGES+1 edges.
  - push to out_valid=1: the same edge the push occurs.
- FIFO:
  - first-word-fall-through; out_data = head entry whenever out_valid=1. out_data holds its last value when empty.
  - Push eligibility uses the occupancy before the edge. A pop in the same cycle does not free a slot for that cycle's push.
  - Simultaneous push and pop: level unchanged, order preserved.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Level is one bit wider, so full and empty are distinct.
- Exactly one push per handshake; duplicate pushes while in ACK_HI are forbidden.
- Reset during a transfer:
  - ack drops immediately and buffered words are discarded.
  - If req is still high after release, the word is captured again as a new transfer. Duplicate delivery across reset is accepted behaviour.

Optional Feature:
Macro HS_RX_PARITY_EN.
- Defined:
  - adds inputs/outputs data_par_in (in 1, even parity over data_in), par_err (out 1, sticky until rst) and par_err_cnt (out 8, saturating at 255).
  - On each capture edge, parity is checked. On mismatch the word is not pushed, par_err<=1 and par_err_cnt increments.
  - The handshake still completes normally (ack asserted), so the sender is not blocked.
  - The FIFO-full check still applies before capture.
- Undefined: no extra ports; every captured word is pushed.

Test Plan:
- Reset: assert rst with req=1, out_ready=0 -> ack=0, out_valid=0, fifo_level=0, stall=0 while asserted; capture resumes SYNC_STAGES+1 edges after release.
- Single transfer (DATA_W=8, SYNC_STAGES=2): data_in=0xA5, raise req -> ack=1 at 3rd clk1 edge, out_valid=1, out_data=0xA5, level=1; drop req -> ack=0 at 3rd edge.
- Backpressure (FIFO_DEPTH=4, out_ready=0): send 0x01..0x05 -> four acked, level=4; 5th req leaves ack=0, stall=1. Pulse out_ready one cycle -> 5th acked; drained order 01,02,03,04,05.
- Simultaneous push/pop at level=2 with out_ready=1 -> level stays 2, out_data advances to next word, no loss.
- Reset while ack=1 and level=3 -> ack=0 and level=0 immediately; req still high -> same word recaptured, level=1, ack=1 three edges after release.
- HS_RX_PARITY_EN: data_in=0x3C, data_par_in=1 -> ack handshake completes, level unchanged, par_err=1, par_err_cnt=1; next 0x3C with par=0 is pushed.

Source files
------------

// File: rtl/hs_rx_sync_fifo.sv
// Receive endpoint of a 4-phase req/ack handshake: req synchroniser, capture FSM and FWFT output FIFO.
// Optional parity checking on captured words is enabled by defining HS_RX_PARITY_EN.
module hs_rx_sync_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                              clk1,
  input  logic                              rst,
  input  logic                              req,
  input  logic [DATA_W-1:0]                 data_in,
  output logic                              ack,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              stall
`ifdef HS_RX_PARITY_EN
  ,
  input  logic                              data_par_in,
  output logic                              par_err,
  output logic [7:0]                        par_err_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, HOLD, ACK_HI} state_t;

  state_t                   state, state_nxt;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     req_s;
  logic [DATA_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr, rd_nxt;
  logic [LVL_W-1:0]         level_nxt;
  logic                     full_c, capture_c, par_ok_c, push_c, pop_c;
  logic [DATA_W-1:0]        head_nxt;

  // Request synchroniser; data_in is only ever sampled once req_s is high
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], req};
  end
  assign req_s = sync_q[SYNC_STAGES-1];

  assign full_c = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop_c  = out_valid & out_ready;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; full check uses occupancy before the edge, so a same-cycle pop never frees a slot
  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (req_s && !full_c) begin
          capture_c = 1'b1;
          state_nxt = ACK_HI;
        end else if (req_s) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!req_s) begin
          state_nxt = IDLE;
        end else if (!full_c) begin
          capture_c = 1'b1;
          state_nxt = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef HS_RX_PARITY_EN
  assign par_ok_c = ~^{data_in, data_par_in};

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      par_err     <= 1'b0;
      par_err_cnt <= 8'd0;
    end else if (capture_c && !par_ok_c) begin
      par_err <= 1'b1;
      if (par_err_cnt != 8'hFF) par_err_cnt <= par_err_cnt + 8'd1;
    end
  end
`else
  assign par_ok_c = 1'b1;
`endif

  assign push_c    = capture_c & par_ok_c;
  assign level_nxt = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
  assign rd_nxt    = rd_ptr + PTR_W'(pop_c);
  // New head bypasses storage when the word being written becomes the head this edge
  assign head_nxt  = (push_c && (wr_ptr == rd_nxt)) ? data_in : mem[rd_nxt];

  always_ff @(posedge clk1) begin
    if (push_c) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      ack        <= 1'b0;
      stall      <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(push_c);
      rd_ptr     <= rd_nxt;
      fifo_level <= level_nxt;
      out_valid  <= (level_nxt != '0);
      if (level_nxt != '0) out_data <= head_nxt;
      ack        <= (state_nxt == ACK_HI);
      stall      <= (state_nxt == HOLD);
    end
  end

endmodule
